alu_pipe: RTL and testbench

Parametrised, two-stage pipelined ALU with valid/ready handshakes on both sides, an internal accumulator operand mode, and a full flag set (carry/borrow, zero, negative, signed overflow). It is the next generation of the team's 4-bit combinational `alu`. It sits between an operand producer and a result consumer, either of which may stall. It sustains one operation per cycle when not back-pressured.

---
 rtl/alu_pkg.sv | 24 ++
 rtl/alu_core.sv | 70 +++++++
 rtl/alu_pipe.sv | 138 +++++++++++++
 tb/tb_alu_pipe.sv | 233 +++++++++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : alu_pkg
//  Description : Shared operation encodings and widths for the pipelined ALU
//                and its combinational core.
//  Revision    : 1.0 - initial release
// ============================================================================
package alu_pkg;

    // Width of the operation select field
    localparam int SEL_W = 3;

    // Operation select encodings
    localparam logic [SEL_W-1:0] OP_ADD   = 3'b000;
    localparam logic [SEL_W-1:0] OP_SUB   = 3'b001;
    localparam logic [SEL_W-1:0] OP_AND   = 3'b010;
    localparam logic [SEL_W-1:0] OP_OR    = 3'b011;
    localparam logic [SEL_W-1:0] OP_XOR   = 3'b100;
    localparam logic [SEL_W-1:0] OP_SHL   = 3'b101;
    localparam logic [SEL_W-1:0] OP_SHR   = 3'b110;
    localparam logic [SEL_W-1:0] OP_PASSB = 3'b111;

endpackage : alu_pkg
`default_nettype wire

// File: rtl/alu_core.sv
`default_nettype none
// ============================================================================
//  Module      : alu_core
//  Description : Purely combinational WIDTH-bit ALU datapath producing the
//                result, carry/borrow/shift-out bit and signed overflow.
//  Revision    : 1.0 - initial release
// ============================================================================
module alu_core
    import alu_pkg::*;
#(
    parameter int WIDTH = 4
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [SEL_W-1:0] sel,
    output logic [WIDTH-1:0] result,
    output logic             carry,
    output logic             ovf
);

    localparam int MSB = WIDTH - 1;

    // Extended-width sum and difference; the top bit is the carry / borrow
    logic [WIDTH:0] w_sum;
    logic [WIDTH:0] w_diff;

    assign w_sum  = {1'b0, a} + {1'b0, b};
    assign w_diff = {1'b0, a} - {1'b0, b};

    // Operation decode; flags default to 0 for logic ops and PASS_B
    always_comb begin
        result = '0;
        carry  = 1'b0;
        ovf    = 1'b0;
        case (sel)
            OP_ADD: begin
                result = w_sum[MSB:0];
                carry  = w_sum[WIDTH];
                // Operands share a sign but the sum does not
                ovf    = (a[MSB] == b[MSB]) && (w_sum[MSB] != a[MSB]);
            end
            OP_SUB: begin
                result = w_diff[MSB:0];
                // Wrap of the extended difference means a < b unsigned
                carry  = w_diff[WIDTH];
                // Operand signs differ and the difference left A's sign
                ovf    = (a[MSB] != b[MSB]) && (w_diff[MSB] != a[MSB]);
            end
            OP_AND: result = a & b;
            OP_OR:  result = a | b;
            OP_XOR: result = a ^ b;
            OP_SHL: begin
                result = {a[MSB-1:0], 1'b0};
                carry  = a[MSB];
            end
            OP_SHR: begin
                result = {1'b0, a[MSB:1]};
                carry  = a[0];
            end
            OP_PASSB: result = b;
            default: begin
                result = '0;
                carry  = 1'b0;
                ovf    = 1'b0;
            end
        endcase
    end

endmodule : alu_core
`default_nettype wire

// File: rtl/alu_pipe.sv
`default_nettype none
// ============================================================================
//  Module      : alu_pipe
//  Description : Two-stage pipelined ALU with valid/ready handshakes on both
//                sides and an accumulator that may stand in for operand A.
//                S1 captures operands; S2 holds the registered result/flags.
//  Revision    : 1.0 - initial release
// ============================================================================
module alu_pipe
    import alu_pkg::*;
#(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic [SEL_W-1:0] Sel,
    input  logic             UseAcc,
    input  logic             AccClr,
    input  logic             in_valid,
    output logic             in_ready,
    output logic [WIDTH-1:0] Result,
    output logic             Carry,
    output logic             Zero,
    output logic             Neg,
    output logic             Ovf,
    output logic             out_valid,
    input  logic             out_ready
);

    // Stage 1 operand registers
    logic             r_s1_valid;
    logic [WIDTH-1:0] r_s1_a;
    logic [WIDTH-1:0] r_s1_b;
    logic [SEL_W-1:0] r_s1_sel;
    logic             r_s1_use_acc;

    // Accumulator
    logic [WIDTH-1:0] r_acc;

    // Stage 2 result registers
    logic             r_out_valid;
    logic [WIDTH-1:0] r_result;
    logic             r_carry;
    logic             r_zero;
    logic             r_neg;
    logic             r_ovf;

    // Handshake and datapath wires
    logic             w_s2_adv;
    logic             w_in_fire;
    logic [WIDTH-1:0] w_eff_a;
    logic [WIDTH-1:0] w_core_result;
    logic             w_core_carry;
    logic             w_core_ovf;

    // S1 moves into S2 when S2 is empty or is being drained this cycle
    assign w_s2_adv  = r_s1_valid & (~r_out_valid | out_ready);
    // Ready depends only on pipeline state, never on in_valid
    assign in_ready  = ~r_s1_valid | w_s2_adv;
    assign w_in_fire = in_valid & in_ready;

    // The accumulator substitutes for A at compute time, so chained ops see
    // the result written on the previous S1->S2 transfer
    assign w_eff_a = r_s1_use_acc ? r_acc : r_s1_a;

    alu_core #(
        .WIDTH (WIDTH)
    ) u_alu_core (
        .a      (w_eff_a),
        .b      (r_s1_b),
        .sel    (r_s1_sel),
        .result (w_core_result),
        .carry  (w_core_carry),
        .ovf    (w_core_ovf)
    );

    // Stage 1: capture operands on an input handshake, empty when drained
    always_ff @(posedge clk) begin
        if (rst) begin
            r_s1_valid   <= 1'b0;
            r_s1_a       <= '0;
            r_s1_b       <= '0;
            r_s1_sel     <= OP_ADD;
            r_s1_use_acc <= 1'b0;
        end else if (w_in_fire) begin
            r_s1_valid   <= 1'b1;
            r_s1_a       <= A;
            r_s1_b       <= B;
            r_s1_sel     <= Sel;
            r_s1_use_acc <= UseAcc;
        end else if (w_s2_adv) begin
            r_s1_valid   <= 1'b0;
        end
    end

    // Stage 2: register result/flags on advance, drop only on output handshake
    always_ff @(posedge clk) begin
        if (rst) begin
            r_out_valid <= 1'b0;
            r_result    <= '0;
            r_carry     <= 1'b0;
            r_zero      <= 1'b0;
            r_neg       <= 1'b0;
            r_ovf       <= 1'b0;
        end else if (w_s2_adv) begin
            r_out_valid <= 1'b1;
            r_result    <= w_core_result;
            r_carry     <= w_core_carry;
            r_zero      <= (w_core_result == '0);
            r_neg       <= w_core_result[WIDTH-1];
            r_ovf       <= w_core_ovf;
        end else if (r_out_valid && out_ready) begin
            r_out_valid <= 1'b0;
        end
    end

    // Accumulator: clear wins over a same-edge write of the transferring op
    always_ff @(posedge clk) begin
        if (rst) begin
            r_acc <= '0;
        end else if (AccClr) begin
            r_acc <= '0;
        end else if (w_s2_adv) begin
            r_acc <= w_core_result;
        end
    end

    assign out_valid = r_out_valid;
    assign Result    = r_result;
    assign Carry     = r_carry;
    assign Zero      = r_zero;
    assign Neg       = r_neg;
    assign Ovf       = r_ovf;

endmodule : alu_pipe
`default_nettype wire

// File: tb/tb_alu_pipe.sv
`default_nettype none
// ============================================================================
//  Module      : tb_alu_pipe
//  Description : Self-checking bench for alu_pipe at WIDTH=4: a vector table
//                for single ops plus accumulate, back-pressure and reset
//                sequences.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_alu_pipe;
    import alu_pkg::*;

    localparam int WIDTH = 4;

    logic             clk;
    logic             rst;
    logic [WIDTH-1:0] A;
    logic [WIDTH-1:0] B;
    logic [SEL_W-1:0] Sel;
    logic             UseAcc;
    logic             AccClr;
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] Result;
    logic             Carry;
    logic             Zero;
    logic             Neg;
    logic             Ovf;
    logic             out_valid;
    logic             out_ready;

    int errors = 0;
    int checks = 0;

    alu_pipe #(
        .WIDTH (WIDTH)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .A         (A),
        .B         (B),
        .Sel       (Sel),
        .UseAcc    (UseAcc),
        .AccClr    (AccClr),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .Result    (Result),
        .Carry     (Carry),
        .Zero      (Zero),
        .Neg       (Neg),
        .Ovf       (Ovf),
        .out_valid (out_valid),
        .out_ready (out_ready)
    );

    // Free-running clock
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Hard time limit so the run always ends
    initial begin
        #200000;
        $display("FAIL watchdog: simulation still running at time limit");
        $fatal(1, "watchdog");
    end

    // Vector record: operands, op, and expected {Result, C, Z, N, O}
    typedef struct packed {
        logic [SEL_W-1:0] sel;
        logic [3:0]       a;
        logic [3:0]       b;
        logic [3:0]       r;
        logic             c;
        logic             z;
        logic             n;
        logic             o;
    } vec_t;

    localparam int NVEC = 13;
    vec_t vecs [NVEC];

    function automatic logic [8:0] out_word();
        return {out_valid, Result, Carry, Zero, Neg, Ovf};
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic drive(input logic [SEL_W-1:0] s, input logic [3:0] a, input logic [3:0] b,
                         input logic ua);
        in_valid = 1'b1;
        Sel      = s;
        A        = a;
        B        = b;
        UseAcc   = ua;
    endtask

    initial begin
        logic [3:0] acc_exp [4];
        int         sent;
        int         got;
        int         accepts_at_block;
        bit         holding;
        logic [3:0] held;

        // ADD / SUB / logic / shift / pass vectors
        vecs[0]  = '{OP_ADD,   4'h3, 4'h5, 4'h8, 1'b0, 1'b0, 1'b1, 1'b1};
        vecs[1]  = '{OP_ADD,   4'hF, 4'h1, 4'h0, 1'b1, 1'b1, 1'b0, 1'b0};
        vecs[2]  = '{OP_SUB,   4'h6, 4'h3, 4'h3, 1'b0, 1'b0, 1'b0, 1'b0};
        vecs[3]  = '{OP_SUB,   4'h2, 4'h4, 4'hE, 1'b1, 1'b0, 1'b1, 1'b0};
        vecs[4]  = '{OP_AND,   4'hA, 4'hC, 4'h8, 1'b0, 1'b0, 1'b1, 1'b0};
        vecs[5]  = '{OP_OR,    4'hA, 4'hC, 4'hE, 1'b0, 1'b0, 1'b1, 1'b0};
        vecs[6]  = '{OP_XOR,   4'hA, 4'hC, 4'h6, 1'b0, 1'b0, 1'b0, 1'b0};
        vecs[7]  = '{OP_SHL,   4'h9, 4'h0, 4'h2, 1'b1, 1'b0, 1'b0, 1'b0};
        vecs[8]  = '{OP_SHR,   4'h9, 4'h0, 4'h4, 1'b1, 1'b0, 1'b0, 1'b0};
        vecs[9]  = '{OP_PASSB, 4'h5, 4'h0, 4'h0, 1'b0, 1'b1, 1'b0, 1'b0};
        vecs[10] = '{OP_SUB,   4'h8, 4'h1, 4'h7, 1'b0, 1'b0, 1'b0, 1'b1};
        vecs[11] = '{OP_ADD,   4'h8, 4'h8, 4'h0, 1'b1, 1'b1, 1'b0, 1'b1};
        vecs[12] = '{OP_PASSB, 4'h0, 4'h9, 4'h9, 1'b0, 1'b0, 1'b1, 1'b0};

        acc_exp[0] = 4'h3;
        acc_exp[1] = 4'h4;
        acc_exp[2] = 4'h5;
        acc_exp[3] = 4'h6;

        rst = 1'b1; A = '0; B = '0; Sel = OP_ADD; UseAcc = 1'b0; AccClr = 1'b0;
        in_valid = 1'b0; out_ready = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;

        // Reset state
        check("reset_outputs", 32'(out_word()), 32'h0);
        check("reset_in_ready", 32'(in_ready), 32'h1);

        // Table: one op at a time, result must appear two edges after accept
        for (int i = 0; i < NVEC; i++) begin
            @(negedge clk);
            drive(vecs[i].sel, vecs[i].a, vecs[i].b, 1'b0);
            check($sformatf("vec%0d_in_ready", i), 32'(in_ready), 32'h1);
            @(negedge clk);
            in_valid = 1'b0;
            check($sformatf("vec%0d_not_early", i), 32'(out_valid), 32'h0);
            @(negedge clk);
            check($sformatf("vec%0d_out", i), 32'(out_word()),
                  32'({1'b1, vecs[i].r, vecs[i].c, vecs[i].z, vecs[i].n, vecs[i].o}));
        end

        // Accumulate: clear, PASS_B 3, then three chained ADDs of 1
        @(negedge clk);
        AccClr = 1'b1;
        @(negedge clk);
        AccClr = 1'b0;
        for (int i = 0; i < 6; i++) begin
            if (i < 2)
                check($sformatf("acc_idle%0d", i), 32'(out_valid), 32'h0);
            else
                check($sformatf("acc_res%0d", i - 2), 32'({out_valid, Result}),
                      32'({1'b1, acc_exp[i - 2]}));
            if (i == 0)
                drive(OP_PASSB, 4'hF, 4'h3, 1'b0);
            else if (i < 4)
                drive(OP_ADD, 4'hF, 4'h1, 1'b1);
            else
                in_valid = 1'b0;
            @(negedge clk);
        end

        // Back-pressure: six PASS_B ops, consumer stalled for four cycles
        sent = 0;
        got = 0;
        accepts_at_block = -1;
        holding = 1'b0;
        held = '0;
        out_ready = 1'b0;
        for (int cyc = 0; cyc < 40 && got < 6; cyc++) begin
            if (cyc == 4) out_ready = 1'b1;
            #1;
            if (out_valid && !out_ready) begin
                if (holding) check($sformatf("bp_stable%0d", cyc), 32'(Result), 32'(held));
                held = Result;
                holding = 1'b1;
            end else begin
                holding = 1'b0;
            end
            if (out_valid && out_ready) begin
                check($sformatf("bp_order%0d", got), 32'(Result), 32'(got + 1));
                got++;
            end
            if (accepts_at_block < 0 && !in_ready) accepts_at_block = sent;
            if (sent < 6) drive(OP_PASSB, 4'h0, 4'(sent + 1), 1'b0);
            else          in_valid = 1'b0;
            if (in_valid && in_ready) sent++;
            @(negedge clk);
        end
        in_valid = 1'b0;
        check("bp_all_received", 32'(got), 32'd6);
        check("bp_accepts_before_block", 32'(accepts_at_block), 32'd2);
        repeat (3) @(negedge clk);
        check("bp_no_duplicate", 32'(out_valid), 32'h0);

        // Reset with S1 and S2 both full and a nonzero accumulator
        out_ready = 1'b0;
        drive(OP_PASSB, 4'h0, 4'h5, 1'b0);
        @(negedge clk);
        drive(OP_PASSB, 4'h0, 4'h9, 1'b0);
        @(negedge clk);
        in_valid = 1'b0;
        check("rst_pipe_full", 32'({out_valid, in_ready}), 32'b10);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("rst_mid_outputs", 32'(out_word()), 32'h0);
        check("rst_mid_in_ready", 32'(in_ready), 32'h1);
        out_ready = 1'b1;
        drive(OP_ADD, 4'h2, 4'h7, 1'b1);
        @(negedge clk);
        in_valid = 1'b0;
        @(negedge clk);
        check("rst_acc_cleared", 32'(out_word()), 32'({1'b1, 4'h7, 1'b0, 1'b0, 1'b0, 1'b0}));
        @(negedge clk);
        check("rst_no_stale", 32'(out_valid), 32'h0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule : tb_alu_pipe
`default_nettype wire
